hazard_scoreboard: RTL

Parametrised Tuse/Tnew hazard unit for the 5-stage pipeline with a multi-cycle MDU. It tracks in-flight destination registers through E, M and W internally, so the datapath supplies only decode-stage information. From that it derives stall/flush, D- and E-stage forwarding selects, and an MDU busy countdown. It sits beside the D/E pipeline registers and drives StallF/StallD/FlushE and the forwarding muxes.

---
 rtl/hazard_scoreboard.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard unit for a 5-stage pipeline with a multi-cycle MDU.
// Tracks in-flight destinations in E/M/W and derives stall, flush, forwarding selects and MDU busy.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int RW       = $clog2(NREG),
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CW       = $clog2(DIV_LAT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dec_valid,
    input  logic [RW-1:0] dec_rs,
    input  logic [RW-1:0] dec_rt,
    input  logic          dec_rs_use,
    input  logic          dec_rt_use,
    input  logic [1:0]    dec_tuse_rs,
    input  logic [1:0]    dec_tuse_rt,
    input  logic [RW-1:0] dec_dst,
    input  logic          dec_wr,
    input  logic [1:0]    dec_tnew,
    input  logic [1:0]    dec_mdu_op,
    output logic          stall,
    output logic          flush_e,
    output logic [1:0]    fwd_rs_d,
    output logic [1:0]    fwd_rt_d,
    output logic [1:0]    fwd_rs_e,
    output logic [1:0]    fwd_rt_e,
    output logic          mdu_busy
);

    localparam logic [1:0] MDU_NONE = 2'b00;
    localparam logic [1:0] MDU_MULT = 2'b01;
    localparam logic [1:0] MDU_DIV  = 2'b10;

    localparam logic [1:0] STG_NONE = 2'd0;
    localparam logic [1:0] STG_E    = 2'd1;
    localparam logic [1:0] STG_M    = 2'd2;
    localparam logic [1:0] STG_W    = 2'd3;

    typedef struct packed {
        logic          valid;
        logic          wr;
        logic [RW-1:0] dst;
        logic [1:0]    tnew;
    } entry_t;

    entry_t        e_q, e_d;
    entry_t        m_q, m_d;
    entry_t        w_q, w_d;
    logic [1:0]    e_mdu_q, e_mdu_d;
    logic [RW-1:0] e_rs_q, e_rs_d;
    logic [RW-1:0] e_rt_q, e_rt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    logic [1:0] rs_stage, rs_tnew, rt_stage, rt_tnew;
    logic       rs_stall, rt_stall, mdu_stall, stall_c;

    function automatic logic hit(input entry_t ent, input logic [RW-1:0] s);
        return ent.valid && ent.wr && (ent.dst == s) && (s != '0);
    endfunction

    // Nearest producer as seen from D: {stage code, tnew}, stage 0 when none.
    function automatic logic [3:0] d_lookup(input entry_t e, input entry_t m,
                                            input entry_t w, input logic [RW-1:0] s);
        if (hit(e, s))      return {STG_E, e.tnew};
        else if (hit(m, s)) return {STG_M, m.tnew};
        else if (hit(w, s)) return {STG_W, w.tnew};
        else                return {STG_NONE, 2'd0};
    endfunction

    // E is the consumer here, so only M and W can supply it.
    function automatic logic [1:0] e_lookup(input entry_t m, input entry_t w,
                                            input logic [RW-1:0] s);
        if (hit(m, s))      return STG_M;
        else if (hit(w, s)) return STG_W;
        else                return STG_NONE;
    endfunction

    always_comb begin
        {rs_stage, rs_tnew} = d_lookup(e_q, m_q, w_q, dec_rs);
        {rt_stage, rt_tnew} = d_lookup(e_q, m_q, w_q, dec_rt);

        fwd_rs_d = ((rs_stage != STG_NONE) && (rs_tnew == 2'd0)) ? rs_stage : STG_NONE;
        fwd_rt_d = ((rt_stage != STG_NONE) && (rt_tnew == 2'd0)) ? rt_stage : STG_NONE;

        fwd_rs_e = e_lookup(m_q, w_q, e_rs_q);
        fwd_rt_e = e_lookup(m_q, w_q, e_rt_q);

        rs_stall = dec_valid && dec_rs_use && (rs_stage != STG_NONE) &&
                   (rs_stage != STG_W) && (rs_tnew > dec_tuse_rs);
        rt_stall = dec_valid && dec_rt_use && (rt_stage != STG_NONE) &&
                   (rt_stage != STG_W) && (rt_tnew > dec_tuse_rt);

        // Any HI/LO access waits for an in-flight mult/div, including one still in E.
        mdu_stall = dec_valid && (dec_mdu_op != MDU_NONE) &&
                    (busy_q || (e_q.valid && ((e_mdu_q == MDU_MULT) || (e_mdu_q == MDU_DIV))));

        stall_c  = rs_stall || rt_stall || mdu_stall;
        stall    = stall_c;
        flush_e  = stall_c;
        mdu_busy = busy_q;
    end

    always_comb begin
        w_d      = m_q;
        w_d.tnew = 2'd0;

        m_d      = e_q;
        m_d.tnew = (e_q.tnew == 2'd0) ? 2'd0 : (e_q.tnew - 2'd1);

        if (dec_valid && !stall_c) begin
            e_d.valid = 1'b1;
            e_d.wr    = dec_wr;
            e_d.dst   = dec_dst;
            e_d.tnew  = dec_tnew;
            e_mdu_d   = dec_mdu_op;
            e_rs_d    = dec_rs;
            e_rt_d    = dec_rt;
        end else begin
            e_d     = '0;
            e_mdu_d = MDU_NONE;
            e_rs_d  = '0;
            e_rt_d  = '0;
        end
    end

    // The load from E wins over the decrement, even on a stall edge.
    always_comb begin
        cnt_d = cnt_q;
        if (e_q.valid && (e_mdu_q == MDU_MULT)) begin
            cnt_d = CW'(MULT_LAT);
        end else if (e_q.valid && (e_mdu_q == MDU_DIV)) begin
            cnt_d = CW'(DIV_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
            e_mdu_q <= MDU_NONE;
            e_rs_q  <= '0;
            e_rt_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            e_q     <= e_d;
            m_q     <= m_d;
            w_q     <= w_d;
            e_mdu_q <= e_mdu_d;
            e_rs_q  <= e_rs_d;
            e_rt_q  <= e_rt_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

endmodule
